// File: rtl/imem_loader.sv
// Streams a word-count header plus big-endian 32-bit words into instruction memory,
// holding the CPU in reset while loading and flagging completion or abort.
module imem_loader #(
  parameter int ADDR_WIDTH = 7,
  parameter int TIMEOUT    = 1000000
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic [7:0]            ByteIn,
  input  logic                  ByteValid,
  output logic                  ByteReady,
  output logic [ADDR_WIDTH-1:0] MemAddress,
  output logic [31:0]           MemWriteData,
  output logic                  MemWrite,
  output logic                  CpuHold,
  output logic                  Done,
  output logic                  Error,
  output logic [15:0]           WordsLoaded
);

  localparam int                TW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]     TMO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [31:0]       CAPACITY  = 32'd1 << ADDR_WIDTH;

  typedef enum logic [2:0] {
    IDLE, HDR_HI, HDR_LO, DATA, WRITE, DONE, ERR
  } state_t;

  state_t                  state_q, state_d;
  logic [15:0]             n_q, n_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [23:0]             asm_q, asm_d;
  logic [1:0]              idx_q, idx_d;
  logic [15:0]             words_q, words_d;
  logic [TW-1:0]           tmo_q, tmo_d;

  logic                    accept;
  logic [15:0]             n_full;

  assign ByteReady    = (state_q == HDR_HI) || (state_q == HDR_LO) || (state_q == DATA);
  assign CpuHold      = ByteReady || (state_q == WRITE);
  assign MemWrite     = (state_q == WRITE);
  assign Done         = (state_q == DONE);
  assign Error        = (state_q == ERR);
  assign MemAddress   = addr_q;
  assign MemWriteData = wdata_q;
  assign WordsLoaded  = words_q;

  assign accept = ByteValid && ByteReady;
  assign n_full = {n_q[15:8], ByteIn};

  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_d = state_q;
    n_d     = n_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    asm_d   = asm_q;
    idx_d   = idx_q;
    words_d = words_q;
    tmo_d   = tmo_q;

    unique case (state_q)
      IDLE, DONE, ERR: begin
        if (Start) begin
          state_d = HDR_HI;
          words_d = '0;
          addr_d  = '0;
          idx_d   = '0;
          tmo_d   = '0;
        end
      end

      // The high header byte may wait forever; the idle counter only runs later.
      HDR_HI: begin
        if (accept) begin
          n_d     = {ByteIn, 8'h00};
          tmo_d   = '0;
          state_d = HDR_LO;
        end
      end

      HDR_LO: begin
        if (accept) begin
          n_d   = n_full;
          tmo_d = '0;
          if (n_full == 16'd0)                   state_d = DONE;
          else if ({16'd0, n_full} > CAPACITY)   state_d = ERR;
          else                                   state_d = DATA;
        end else if (tmo_q == TMO_LAST) begin
          state_d = ERR;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      DATA: begin
        if (accept) begin
          tmo_d = '0;
          asm_d = {asm_q[15:0], ByteIn};
          if (idx_q == 2'd3) begin
            // Output word only changes here, so it stays put outside WRITE.
            wdata_d = {asm_q, ByteIn};
            idx_d   = '0;
            state_d = WRITE;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d = ERR;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      WRITE: begin
        addr_d  = addr_q + ADDR_WIDTH'(1);
        words_d = words_q + 16'd1;
        state_d = ((words_q + 16'd1) == n_q) ? DONE : DATA;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      n_q     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      asm_q   <= '0;
      idx_q   <= '0;
      words_q <= '0;
      tmo_q   <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values of the others.
      state_q <= state_d;
      n_q     <= n_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      asm_q   <= asm_d;
      idx_q   <= idx_d;
      words_q <= words_d;
      tmo_q   <= tmo_d;
    end
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter ADDR_WIDTH, default 7: word-address width; capacity 2^ADDR_WIDTH 32-bit words.
REQ-002 Parameter TIMEOUT, default 1000000: maximum idle cycles allowed between accepted bytes mid-load.
REQ-003 Clk  input  1  single clock; all state updates on rising edge.
REQ-004 Reset  input  1  asynchronous, active-low reset.
REQ-005 Start  input  1  single-cycle pulse that begins a load session.
REQ-006 ByteIn  input  8  incoming stream byte.
REQ-007 ByteValid  input  1  ByteIn holds a valid byte.
REQ-008 ByteReady  output  1  loader can accept a byte this cycle.
REQ-009 MemAddress  output  ADDR_WIDTH  instruction-memory word address.
REQ-010 MemWriteData  output  32  word to write.
REQ-011 MemWrite  output  1  write strobe, one cycle per word.
REQ-012 CpuHold  output  1  holds the fetch unit in reset while loading.
REQ-013 Done  output  1  load completed successfully.
REQ-014 Error  output  1  load aborted.
REQ-015 WordsLoaded  output  16  count of words written this session.

Function
REQ-016 The loader SHALL use states IDLE, HDR_HI, HDR_LO, DATA, WRITE, DONE, ERR.
REQ-017 A byte SHALL be accepted only on a rising edge with ByteValid=1 and ByteReady=1.
REQ-018 ByteReady SHALL be 1 in HDR_HI, HDR_LO, DATA only; 0 in IDLE, WRITE, DONE, ERR.
REQ-019 IDLE/DONE/ERR + Start=1 -> HDR_HI; clears WordsLoaded, MemAddress, byte index, Done, Error, timeout counter.
REQ-020 Start in HDR_HI, HDR_LO, DATA, WRITE SHALL be ignored.
REQ-021 HDR_HI accepts word-count N[15:8]; HDR_LO accepts N[7:0].
REQ-022 After HDR_LO: N=0 -> DONE; N>2^ADDR_WIDTH -> ERR; else -> DATA.
REQ-023 DATA assembles big-endian: first accepted byte -> bits [31:24], fourth -> [7:0].
REQ-024 On the fourth byte's acceptance the state SHALL move to WRITE on the next edge.
REQ-025 In WRITE, MemWrite=1 for exactly one cycle with MemAddress and complete MemWriteData stable.
REQ-026 Edge leaving WRITE: MemAddress +1, WordsLoaded +1; next state DONE if WordsLoaded+1=N, else DATA.
REQ-027 Latency: 4th byte accepted at edge k -> MemWrite high during cycle k..k+1 -> ByteReady high again after edge k+1.
REQ-028 MemAddress SHALL NOT wrap within a session (guaranteed by REQ-022).
REQ-029 CpuHold SHALL be 1 in HDR_HI, HDR_LO, DATA, WRITE and 0 elsewhere.
REQ-030 Timeout counter counts cycles in HDR_LO/DATA without an accepted byte; cleared on acceptance; reaching TIMEOUT -> ERR.
REQ-031 HDR_HI SHALL never time out.
REQ-032 Done=1 only in DONE; Error=1 only in ERR; both held until next Start or reset.
REQ-033 In ERR, already-written words SHALL remain; WordsLoaded holds the count reached.
REQ-034 MemWriteData SHALL hold its last value outside WRITE; MemWrite SHALL be 0 outside WRITE.

Reset
REQ-035 Reset=0 SHALL immediately force IDLE, ByteReady=0, MemWrite=0, CpuHold=0, Done=0, Error=0, MemAddress=0, MemWriteData=0, WordsLoaded=0, timeout and byte index 0.
REQ-036 Reset asserted mid-load SHALL abort with no further MemWrite; partial word discarded.

Verification
REQ-037 Start; bytes 00 02 12 34 56 78 AA BB CC DD -> writes 0x12345678 @0, 0xAABBCCDD @1; Done=1, CpuHold=0, WordsLoaded=2.
REQ-038 Start; header 00 00 -> DONE next edge, no MemWrite, Done=1, WordsLoaded=0.
REQ-039 ADDR_WIDTH=7; header 00 81 -> Error=1, no MemWrite; header 00 80 accepted.
REQ-040 TIMEOUT=16; header 00 01, two data bytes, then ByteValid=0 for 16 cycles -> Error=1, CpuHold=0, no MemWrite.
REQ-041 ByteValid held 1 continuously across 4th byte -> ByteReady 0 during WRITE; 5th byte accepted edge after WRITE, none dropped or duplicated.
REQ-042 Reset low after 2 of 3 words -> outputs at reset values asynchronously; Start afterward reloads from MemAddress 0.
